mem_port_arbiter: RTL and testbench

Single-port memory arbiter and boot/vector sequencer for the pipelined 8-bit core. It shares one synchronous-read RAM between instruction fetch (IF), the memory stage (MEM: LDD/STD/LDI/STI/PUSH/POP/CALL/RET/interrupt push), and interrupt-vector fetch. It also owns the post-reset boot read that loads the PC from M[BOOT_ADDR]. It sits between the pipeline front-end/MEM stage and the unified RAM, and drives the stall and PC-load signals consumed by the control unit.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the unified RAM and the arbiter.
// The slave side is the arbiter. The master side is the surrounding core and RAM.
interface mem_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_stall;
   logic          if_rvalid;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic          vec_req;
   logic          vec_gnt;
   logic [DW-1:0] rdata;
   logic          pc_load;
   logic [DW-1:0] pc_load_val;
   logic          boot_done;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, vec_req, ram_rdata,
      output if_gnt, if_stall, if_rvalid, mem_gnt, mem_rvalid, vec_gnt, rdata,
             pc_load, pc_load_val, boot_done, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, vec_req, ram_rdata,
      input  if_gnt, if_stall, if_rvalid, mem_gnt, mem_rvalid, vec_gnt, rdata,
             pc_load, pc_load_val, boot_done, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch, MEM stage and interrupt vector reads.
// It also performs the post-reset boot read that loads the PC.
module mem_port_arbiter #(
   parameter int            AW         = 8,
   parameter int            DW         = 8,
   parameter logic [AW-1:0] BOOT_ADDR  = AW'(0),
   parameter logic [AW-1:0] INT_ADDR   = AW'(1),
   parameter int            STARVE_MAX = 4
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam logic [1:0] ST_BOOT      = 2'd0;
   localparam logic [1:0] ST_BOOT_WAIT = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_IF   = 2'd1;
   localparam logic [1:0] TAG_MEM  = 2'd2;
   localparam logic [1:0] TAG_VEC  = 2'd3;

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [1:0]    state;
   logic [1:0]    tag;
   logic [CW-1:0] count;
   logic          boot_done_r;
   logic          starved;

   assign starved = (count == CW'(STARVE_MAX));

   // Grant selection: vector beats MEM, and MEM yields to a starved fetch
   always_comb begin
      bus.vec_gnt  = 1'b0;
      bus.mem_gnt  = 1'b0;
      bus.if_gnt   = 1'b0;
      bus.ram_en   = 1'b0;
      bus.ram_we   = 1'b0;
      bus.ram_addr = bus.if_addr;
      case (state)
         ST_BOOT: begin
            bus.ram_en   = ~rst;
            bus.ram_addr = BOOT_ADDR;
         end
         ST_RUN: begin
            if (bus.vec_req) begin
               bus.vec_gnt  = 1'b1;
               bus.ram_en   = 1'b1;
               bus.ram_addr = INT_ADDR;
            end else if (bus.mem_req && !(starved && bus.if_req)) begin
               bus.mem_gnt  = 1'b1;
               bus.ram_en   = 1'b1;
               bus.ram_we   = bus.mem_we;
               bus.ram_addr = bus.mem_addr;
            end else if (bus.if_req) begin
               bus.if_gnt   = 1'b1;
               bus.ram_en   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.if_stall    = bus.if_req & ~bus.if_gnt;
   assign bus.ram_wdata   = bus.mem_wdata;
   assign bus.rdata       = bus.ram_rdata;
   assign bus.pc_load_val = bus.ram_rdata;
   assign bus.if_rvalid   = (tag == TAG_IF);
   assign bus.mem_rvalid  = (tag == TAG_MEM);
   assign bus.pc_load     = (state == ST_BOOT_WAIT) || (tag == TAG_VEC);
   assign bus.boot_done   = boot_done_r;

   // Async reset drops any in-flight return tag so no stale strobe follows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_BOOT;
         tag         <= TAG_NONE;
         count       <= '0;
         boot_done_r <= 1'b0;
      end else begin
         case (state)
            ST_BOOT:      state <= ST_BOOT_WAIT;
            ST_BOOT_WAIT: begin
               state       <= ST_RUN;
               boot_done_r <= 1'b1;
            end
            ST_RUN:       state <= ST_RUN;
            default:      state <= ST_BOOT;
         endcase

         if (bus.vec_gnt)
            tag <= TAG_VEC;
         else if (bus.mem_gnt && !bus.mem_we)
            tag <= TAG_MEM;
         else if (bus.if_gnt)
            tag <= TAG_IF;
         else
            tag <= TAG_NONE;

         if ((state == ST_RUN) && bus.if_req && !bus.if_gnt) begin
            if (!starved)
               count <= count + 1'b1;
         end else if (bus.if_gnt || !bus.if_req) begin
            count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first synchronous RAM model
// and a return-strobe scoreboard.
module tb_mem_port_arbiter;

   localparam logic [2:0] K_NONE = 3'b000;
   localparam logic [2:0] K_IF   = 3'b001;
   localparam logic [2:0] K_MEM  = 3'b010;
   localparam logic [2:0] K_VEC  = 3'b100;

   typedef struct packed {
      logic [2:0] kind;
      logic [7:0] d;
   } ret_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   ret_t q[$];
   logic [7:0] ram [256];

   mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

   mem_port_arbiter #(
      .AW(8), .DW(8), .BOOT_ADDR(8'h00), .INT_ADDR(8'h01), .STARVE_MAX(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: preloaded while reset is high, write-first, 1-cycle read
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 256; k++) ram[k] <= 8'(k) ^ 8'h5A;
         ram[8'h00] <= 8'h20;
         ram[8'h01] <= 8'h40;
         ram[8'h20] <= 8'hA1;
         ram[8'h21] <= 8'hA2;
         ram[8'h22] <= 8'hA3;
         ram[8'h23] <= 8'hA4;
         ram[8'hF0] <= 8'h55;
      end else if (bus.ram_en) begin
         if (bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata     <= bus.ram_wdata;
         end else begin
            bus.ram_rdata <= ram[bus.ram_addr];
         end
      end
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      ret_t       e;
      logic [2:0] obs;
      @(negedge clk);
      obs = {bus.pc_load, bus.mem_rvalid, bus.if_rvalid};
      if (q.size() > 0) begin
         e = q.pop_front();
         chk8("strobe", 8'(obs), 8'(e.kind));
         if (e.kind == K_VEC)
            chk8("pc_load_val", bus.pc_load_val, e.d);
         else
            chk8("rdata", bus.rdata, e.d);
      end else begin
         chk8("strobe_idle", 8'(obs), 8'(K_NONE));
      end
   endtask

   task automatic cyc(input logic v, input logic m, input logic we, input logic [7:0] ma,
                      input logic [7:0] wd, input logic i, input logic [7:0] ia,
                      input logic [2:0] g, input logic [7:0] d);
      logic [7:0] ea;
      bus.vec_req   = v;
      bus.mem_req   = m;
      bus.mem_we    = we;
      bus.mem_addr  = ma;
      bus.mem_wdata = wd;
      bus.if_req    = i;
      bus.if_addr   = ia;
      #1;
      ea = (g == K_VEC) ? 8'h01 : (g == K_MEM) ? ma : ia;
      chk1("vec_gnt", bus.vec_gnt, g == K_VEC);
      chk1("mem_gnt", bus.mem_gnt, g == K_MEM);
      chk1("if_gnt", bus.if_gnt, g == K_IF);
      chk1("if_stall", bus.if_stall, i && (g != K_IF));
      chk1("ram_en", bus.ram_en, g != K_NONE);
      chk1("ram_we", bus.ram_we, (g == K_MEM) && we);
      if (g != K_NONE) chk8("ram_addr", bus.ram_addr, ea);
      if ((g == K_MEM) && we) chk8("ram_wdata", bus.ram_wdata, wd);
      if ((g != K_NONE) && !((g == K_MEM) && we)) q.push_back('{kind: g, d: d});
      tick();
   endtask

   // Entered at a falling edge with rst high; leaves the core in RUN.
   task automatic do_boot();
      rst         = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h20;
      bus.mem_req = 1'b0;
      bus.vec_req = 1'b0;
      #1;
      chk1("boot_ram_en", bus.ram_en, 1'b1);
      chk8("boot_ram_addr", bus.ram_addr, 8'h00);
      chk1("boot_ram_we", bus.ram_we, 1'b0);
      chk1("boot_if_gnt", bus.if_gnt, 1'b0);
      chk1("boot_if_stall", bus.if_stall, 1'b1);
      chk1("boot_done_c0", bus.boot_done, 1'b0);
      q.push_back('{kind: K_VEC, d: 8'h20});
      tick();
      chk1("bootwait_if_gnt", bus.if_gnt, 1'b0);
      chk1("bootwait_ram_en", bus.ram_en, 1'b0);
      chk1("boot_done_c1", bus.boot_done, 1'b0);
      tick();
      chk1("boot_done_c2", bus.boot_done, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.if_req    = 1'b1;
      bus.if_addr   = 8'h20;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 8'hF0;
      bus.mem_wdata = 8'h00;
      bus.vec_req   = 1'b1;
      bus.ram_rdata = 8'h00;
      #2;
      chk1("rst_if_gnt", bus.if_gnt, 1'b0);
      chk1("rst_mem_gnt", bus.mem_gnt, 1'b0);
      chk1("rst_vec_gnt", bus.vec_gnt, 1'b0);
      chk1("rst_pc_load", bus.pc_load, 1'b0);
      chk1("rst_ram_we", bus.ram_we, 1'b0);
      chk1("rst_ram_en", bus.ram_en, 1'b0);
      chk1("rst_boot_done", bus.boot_done, 1'b0);
      chk1("rst_if_rvalid", bus.if_rvalid, 1'b0);
      @(negedge clk);
      do_boot();

      // Fetch stream, one grant per cycle
      cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h20, K_IF, 8'hA1);
      cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h21, K_IF, 8'hA2);
      cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h22, K_IF, 8'hA3);

      // MEM read beats fetch; then write and read-back of the same address
      cyc(0, 1, 0, 8'hF0, 8'h00, 1, 8'h23, K_MEM, 8'h55);
      cyc(0, 1, 1, 8'hF0, 8'h77, 0, 8'h23, K_MEM, 8'h00);
      cyc(0, 1, 0, 8'hF0, 8'h00, 0, 8'h23, K_MEM, 8'h77);

      // Starvation: four MEM grants then one forced fetch, twice
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            cyc(0, 1, 0, 8'hF0, 8'h00, 1, 8'h23, K_MEM, 8'h77);
         cyc(0, 1, 0, 8'hF0, 8'h00, 1, 8'h23, K_IF, 8'hA4);
      end

      // Vector wins over everything; MEM follows alongside the pc_load strobe
      cyc(1, 1, 0, 8'hF0, 8'h00, 1, 8'h23, K_VEC, 8'h40);
      cyc(0, 1, 0, 8'hF0, 8'h00, 1, 8'h23, K_MEM, 8'h77);
      cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, K_NONE, 8'h00);

      // Reset asserted in the cycle after a fetch grant kills its return
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h21;
      #1;
      chk1("pre_rst_if_gnt", bus.if_gnt, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk1("midrst_boot_done", bus.boot_done, 1'b0);
      @(negedge clk);
      chk1("midrst_if_rvalid", bus.if_rvalid, 1'b0);
      chk1("midrst_pc_load", bus.pc_load, 1'b0);
      chk1("midrst_if_gnt", bus.if_gnt, 1'b0);
      do_boot();
      cyc(0, 0, 0, 8'h00, 8'h00, 1, 8'h21, K_IF, 8'hA2);
      cyc(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, K_NONE, 8'h00);
      chk1("queue_empty", q.size() == 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
